inst_encoder: RTL and testbench

RV32I instruction encoder and program loader, the inverse of the instruction decode stage. Accepts decoded instruction fields (opcode, register indices, funct fields, 32-bit immediate) over a valid/ready handshake, range-checks the immediate against the opcode's format, and packs a 32-bit instruction word. Emits each word with a sequential word address for writing into instruction memory. Used by test infrastructure and boot loading to fill instruction RAM.

---
 rtl/inst_encoder_pkg.sv | 33 +++
 rtl/inst_encoder_if.sv | 35 +++
 rtl/inst_encoder_pack.sv | 65 ++++++
 rtl/inst_encoder.sv | 118 +++++++++++
 tb/tb_inst_encoder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode constants, error codes and loader state for the instruction encoder.
package inst_encoder_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_RANGE  = 2'b10,
        ERR_ALIGN  = 2'b11
    } err_code_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } ld_state_e;

    // True when v is the sign-extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] ext;
        ext = $signed(v << (32 - bits)) >>> (32 - bits);
        return ext == $signed(v);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-in / word-out bus of the instruction encoder; master drives fields, slave is the encoder.
interface inst_encoder_if
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) ();
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm32;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    err_code_e         err_code;

    modport master (
        output clear, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm32, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, count, full, err, err_code
    );

    modport slave (
        input  clear, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm32, out_ready,
        output in_ready, out_valid, out_inst, out_addr, count, full, err, err_code
    );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I packer: decoded fields in, instruction word plus range/alignment verdict out.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm32,
    output logic [31:0] inst,
    output logic        err,
    output err_code_e   err_code
);
    logic is_shift;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        inst     = '0;
        err_code = ERR_NONE;
        case (opcode)
            OP_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_I: begin
                if (is_shift) begin
                    inst = {funct7, imm32[4:0], rs1, funct3, rd, opcode};
                    if (imm32[31:5] != '0) err_code = ERR_RANGE;
                end else begin
                    inst = {imm32[11:0], rs1, funct3, rd, opcode};
                    if (!fits_signed(imm32, 12)) err_code = ERR_RANGE;
                end
            end
            OP_L: begin
                inst = {imm32[11:0], rs1, funct3, rd, opcode};
                if (!fits_signed(imm32, 12)) err_code = ERR_RANGE;
            end
            OP_JALR: begin
                inst = {imm32[11:0], rs1, 3'b000, rd, opcode};
                if (!fits_signed(imm32, 12)) err_code = ERR_RANGE;
            end
            OP_S: begin
                inst = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
                if (!fits_signed(imm32, 12)) err_code = ERR_RANGE;
            end
            // Range is judged before alignment so an odd, out-of-range offset reports range.
            OP_B: begin
                inst = {imm32[12], imm32[10:5], rs2, rs1, funct3, imm32[4:1], imm32[11], opcode};
                if (!fits_signed(imm32, 13)) err_code = ERR_RANGE;
                else if (imm32[0])           err_code = ERR_ALIGN;
            end
            OP_LUI, OP_AUIPC: begin
                inst = {imm32[31:12], rd, opcode};
                if (imm32[11:0] != '0) err_code = ERR_RANGE;
            end
            OP_JAL: begin
                inst = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
                if (!fits_signed(imm32, 21)) err_code = ERR_RANGE;
                else if (imm32[0])           err_code = ERR_ALIGN;
            end
            default: err_code = ERR_OPCODE;
        endcase
        err = (err_code != ERR_NONE);
    end
endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder / program loader: packs fields into words and emits them at sequential addresses.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_encoder_if.slave  bus
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    ld_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    logic              full;
    logic              in_ready;
    logic              fire;
    logic              load;
    logic              reject;
    logic [31:0]       pack_inst;
    logic              pack_err;
    err_code_e         pack_code;

    inst_pack u_pack (
        .opcode   (bus.opcode),
        .rd       (bus.rd),
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .imm32    (bus.imm32),
        .inst     (pack_inst),
        .err      (pack_err),
        .err_code (pack_code)
    );

    // clear wins over a same-cycle transfer: the handshake completes but the fields are dropped.
    assign fire   = bus.in_valid && in_ready;
    assign load   = fire && !bus.clear && !pack_err;
    assign reject = fire && !bus.clear && pack_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear)
            state_d = ST_RUN;
        else if (state_q == ST_RUN && load && (count_q + 1'b1) == DEPTH_C)
            state_d = ST_FULL;
    end

    always_comb begin
        full     = (state_q == ST_FULL);
        in_ready = !full && (!out_valid_q || bus.out_ready);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        err_d       = reject;
        err_code_d  = err_code_q;
        if (bus.clear) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            err_code_d  = ERR_NONE;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
            if (load) begin
                out_valid_d = 1'b1;
                out_inst_d  = pack_inst;
                out_addr_d  = BASE_C + count_q[ADDR_W-1:0];
                count_d     = count_q + 1'b1;
            end
            if (reject) err_code_d = pack_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= BASE_C;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed cases plus randomized traffic against an arithmetic reference model.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int BASE_A  = 0;
    localparam int DEPTH_A = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(10)) bus_a ();
    inst_encoder_if #(.ADDR_W(10)) bus_b ();

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(BASE_A), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    inst_encoder #(.ADDR_W(10), .BASE_ADDR('h10), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] q_inst[$];
    logic [9:0]  q_addr[$];
    int          m_count;
    logic [1:0]  m_code;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bf(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    // Reference encoder: fields placed by shift, ranges judged on the signed integer value.
    function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, output logic [31:0] w, output logic [1:0] code);
        longint s;
        logic [31:0] base;
        s = $signed(imm);
        code = 2'd0;
        w = 32'h0;
        base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (op)
            7'h33: w = base | (32'(rs2) << 20) | (32'(f7) << 25);
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (imm > 32'd31) code = 2'd2;
                    w = base | (bf(imm, 4, 0) << 20) | (32'(f7) << 25);
                end else begin
                    if (s < -2048 || s > 2047) code = 2'd2;
                    w = base | (bf(imm, 11, 0) << 20);
                end
            end
            7'h03: begin
                if (s < -2048 || s > 2047) code = 2'd2;
                w = base | (bf(imm, 11, 0) << 20);
            end
            7'h67: begin
                if (s < -2048 || s > 2047) code = 2'd2;
                w = (base & ~(32'h7 << 12)) | (bf(imm, 11, 0) << 20);
            end
            7'h23: begin
                if (s < -2048 || s > 2047) code = 2'd2;
                w = (base & ~(32'h1F << 7)) | (bf(imm, 4, 0) << 7) | (32'(rs2) << 20) | (bf(imm, 11, 5) << 25);
            end
            7'h63: begin
                if (s < -4096 || s > 4095) code = 2'd2;
                else if (imm % 2 != 0)     code = 2'd3;
                w = 32'(op) | (bf(imm, 11, 11) << 7) | (bf(imm, 4, 1) << 8) | (32'(f3) << 12)
                  | (32'(rs1) << 15) | (32'(rs2) << 20) | (bf(imm, 10, 5) << 25) | (bf(imm, 12, 12) << 31);
            end
            7'h37, 7'h17: begin
                if (imm % 4096 != 0) code = 2'd2;
                w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
            end
            7'h6F: begin
                if (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 1) code = 2'd2;
                else if (imm % 2 != 0)                             code = 2'd3;
                w = 32'(op) | (32'(rd) << 7) | (bf(imm, 19, 12) << 12) | (bf(imm, 11, 11) << 20)
                  | (bf(imm, 10, 1) << 21) | (bf(imm, 20, 20) << 31);
            end
            default: code = 2'd1;
        endcase
    endfunction

    task automatic m_reset();
        q_inst.delete();
        q_addr.delete();
        m_count = 0;
        m_code  = 2'd0;
    endtask

    task automatic set_a(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input logic v);
        bus_a.opcode = op; bus_a.rd = rd; bus_a.rs1 = rs1; bus_a.rs2 = rs2;
        bus_a.funct3 = f3; bus_a.funct7 = f7; bus_a.imm32 = imm; bus_a.in_valid = v;
    endtask

    // One clock of dut_a: inputs already driven; checks the pre-edge view, advances, checks the post-edge view.
    task automatic cycle_a();
        logic iv, ir, ov, ordy, exp_err;
        logic [31:0] w;
        logic [1:0] code;
        #1;
        iv = bus_a.in_valid; ir = bus_a.in_ready; ov = bus_a.out_valid; ordy = bus_a.out_ready;
        exp_err = 1'b0;
        chk("in_ready", ir, (m_count != DEPTH_A) && (!ov || ordy));
        chk("out_valid", ov, q_inst.size() != 0);
        if (ov && q_inst.size() != 0) begin
            chk("out_inst", bus_a.out_inst, q_inst[0]);
            chk("out_addr", bus_a.out_addr, q_addr[0]);
        end
        if (bus_a.clear) begin
            m_reset();
        end else begin
            if (ov && ordy && q_inst.size() != 0) begin
                void'(q_inst.pop_front());
                void'(q_addr.pop_front());
            end
            if (iv && ir) begin
                ref_enc(bus_a.opcode, bus_a.rd, bus_a.rs1, bus_a.rs2, bus_a.funct3, bus_a.funct7,
                        bus_a.imm32, w, code);
                if (code != 2'd0) begin
                    exp_err = 1'b1;
                    m_code  = code;
                end else begin
                    q_inst.push_back(w);
                    q_addr.push_back(10'(BASE_A + m_count));
                    m_count++;
                end
            end
        end
        @(posedge clk); #1;
        chk("err", bus_a.err, exp_err);
        chk("err_code", bus_a.err_code, m_code);
        chk("count", bus_a.count, m_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops[10];
        logic [31:0] bnd[16];
        logic [31:0] w, imm;
        logic [1:0]  code;
        logic [6:0]  op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
        bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd31, 32'd32, 32'd4094, 32'd4095,
                -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, -32'sd1048578,
                32'd4096, 32'd0};

        rst_n = 1'b0;
        set_a(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        bus_a.clear = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.clear = 1'b0; bus_b.out_ready = 1'b0; bus_b.in_valid = 1'b0;
        bus_b.opcode = 7'h13; bus_b.rd = 5'd1; bus_b.rs1 = 5'd0; bus_b.rs2 = 5'd0;
        bus_b.funct3 = 3'd0; bus_b.funct7 = 7'd0; bus_b.imm32 = 32'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_out_inst", bus_a.out_inst, 32'h0);
        chk("rst_out_addr", bus_a.out_addr, 10'h0);
        chk("rst_count", bus_a.count, 11'h0);
        chk("rst_full", bus_a.full, 1'b0);
        chk("rst_err", bus_a.err, 1'b0);
        chk("rst_err_code", bus_a.err_code, 2'b00);
        chk("rst_b_out_addr", bus_b.out_addr, 10'h10);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", bus_a.in_ready, 1'b1);

        bus_a.out_ready = 1'b1;
        set_a(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        cycle_a();
        chk("add_inst", bus_a.out_inst, 32'h002081B3);
        chk("add_addr", bus_a.out_addr, 10'd0);
        chk("add_count", bus_a.count, 11'd1);
        set_a(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1);
        cycle_a();
        chk("srai_inst", bus_a.out_inst, 32'h40335293);
        set_a(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1);
        cycle_a();
        chk("beq_inst", bus_a.out_inst, 32'hFE208EE3);
        chk("beq_addr", bus_a.out_addr, 10'd2);
        set_a(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
        cycle_a();
        chk("addi_range_code", bus_a.err_code, 2'b10);
        chk("reject_no_word", bus_a.out_valid, 1'b0);
        set_a(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        cycle_a();
        chk("after_reject_addr", bus_a.out_addr, 10'd3);
        chk("err_code_holds", bus_a.err_code, 2'b10);
        set_a(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1);
        cycle_a();
        chk("jal_align_code", bus_a.err_code, 2'b11);
        set_a(7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        cycle_a();
        chk("bad_opcode_code", bus_a.err_code, 2'b01);
        bus_a.in_valid = 1'b0;
        cycle_a();

        set_a(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        cycle_a();
        bus_a.out_ready = 1'b0;
        set_a(7'h17, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 1'b1);
        repeat (3) begin
            cycle_a();
            chk("stall_in_ready", bus_a.in_ready, 1'b0);
        end
        bus_a.out_ready = 1'b1;
        cycle_a();
        bus_a.in_valid = 1'b0;
        cycle_a();
        cycle_a();

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(9)];
            if (op == 7'h0B) op = 7'($urandom);
            case ($urandom_range(4))
                0: imm = 32'($signed($urandom_range(31)) - 16);
                1: imm = bnd[$urandom_range(15)];
                2: imm = $urandom;
                3: imm = 32'($signed($urandom_range(8191)) - 4096) & ~32'h1;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            set_a(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm,
                  $urandom_range(9) < 7);
            bus_a.out_ready = ($urandom_range(3) != 0);
            cycle_a();
        end
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        cycle_a();
        cycle_a();
        chk("queue_drained", q_inst.size(), 0);

        bus_a.out_ready = 1'b0;
        set_a(7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'd0, 32'd0, 1'b1);
        cycle_a();
        bus_a.clear = 1'b1;
        set_a(7'h33, 5'd9, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0, 1'b1);
        cycle_a();
        bus_a.clear = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("clear_out_valid", bus_a.out_valid, 1'b0);
        chk("clear_count", bus_a.count, 11'd0);
        chk("clear_err_code", bus_a.err_code, 2'b00);
        bus_a.out_ready = 1'b1;
        set_a(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1);
        cycle_a();
        chk("after_clear_addr", bus_a.out_addr, 10'd0);

        set_a(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        cycle_a();
        bus_a.out_ready = 1'b0;
        set_a(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b1);
        cycle_a();
        bus_a.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus_a.out_valid, 1'b0);
        chk("arst_out_inst", bus_a.out_inst, 32'h0);
        chk("arst_out_addr", bus_a.out_addr, 10'h0);
        chk("arst_count", bus_a.count, 11'h0);
        chk("arst_err_code", bus_a.err_code, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;

        bus_b.out_ready = 1'b1;
        bus_b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.imm32 = 32'(i);
            @(posedge clk); #1;
            ref_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), w, code);
            chk("b_inst", bus_b.out_inst, w);
            chk("b_addr", bus_b.out_addr, 10'(16 + i));
            chk("b_count", bus_b.count, 11'(i + 1));
        end
        chk("b_full", bus_b.full, 1'b1);
        chk("b_full_in_ready", bus_b.in_ready, 1'b0);
        chk("b_last_valid", bus_b.out_valid, 1'b1);
        @(posedge clk); #1;
        chk("b_drained", bus_b.out_valid, 1'b0);
        chk("b_no_extra", bus_b.count, 11'd4);
        bus_b.clear = 1'b1;
        @(posedge clk); #1;
        bus_b.clear = 1'b0;
        chk("b_clear_count", bus_b.count, 11'd0);
        chk("b_clear_full", bus_b.full, 1'b0);
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        chk("b_restart_addr", bus_b.out_addr, 10'h10);
        chk("b_restart_count", bus_b.count, 11'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
